// File: rtl/apb_master_arb_if.sv
// APB bus bundle shared by the upstream requesters and the downstream port.
interface apb_master_arb_if;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pwstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata, pwstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata, pwstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_master_arb.sv
// Two-master APB arbiter: round-robin or fixed priority, registered downstream
// request, combinational response pass-through and ACCESS-phase timeout.
//
// state  | meaning
// IDLE   | no transfer; arbitrate and latch the winner's request
// SETUP  | downstream psel=1, penable=0
// ACCESS | downstream psel=1, penable=1; wait for pready or timeout
module apb_master_arb #(
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 256
) (
    input  logic             clk,
    input  logic             rst,
    apb_master_arb_if.slave  m0,
    apb_master_arb_if.slave  m1,
    apb_master_arb_if.master ds,
    output logic             grant,
    output logic             timeout_evt
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic [31:0] CNT_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic [31:0] cnt;
    logic        req_any;
    logic        win;
    logic        done;
    logic        to_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_any     = m0.psel | m1.psel;
        win         = m1.psel;
        to_hit      = 1'b0;
        done        = 1'b0;
        timeout_evt = 1'b0;
        m0.pready   = 1'b0;
        m0.prdata   = '0;
        m0.pslverr  = 1'b0;
        m1.pready   = 1'b0;
        m1.prdata   = '0;
        m1.pslverr  = 1'b0;

        // On a tie, round-robin favours whoever was not served last.
        if (m0.psel && m1.psel) begin
            win = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end

        case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                to_hit = (TIMEOUT != 0) && !ds.pready && (cnt == CNT_LAST);
                done   = ds.pready | to_hit;
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        timeout_evt = to_hit;

        // A forced completion returns zero data with an error.
        if (done) begin
            if (grant == 1'b0) begin
                m0.pready  = 1'b1;
                m0.prdata  = to_hit ? 32'h0 : ds.prdata;
                m0.pslverr = to_hit | ds.pslverr;
            end else begin
                m1.pready  = 1'b1;
                m1.prdata  = to_hit ? 32'h0 : ds.prdata;
                m1.pslverr = to_hit | ds.pslverr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ds.psel    <= 1'b0;
            ds.penable <= 1'b0;
            ds.paddr   <= '0;
            ds.pwrite  <= 1'b0;
            ds.pwdata  <= '0;
            ds.pwstrb  <= '0;
            grant      <= 1'b1;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        ds.psel   <= 1'b1;
                        grant     <= win;
                        ds.paddr  <= win ? m1.paddr  : m0.paddr;
                        ds.pwrite <= win ? m1.pwrite : m0.pwrite;
                        ds.pwdata <= win ? m1.pwdata : m0.pwdata;
                        ds.pwstrb <= win ? m1.pwstrb : m0.pwstrb;
                    end
                end
                SETUP: begin
                    ds.penable <= 1'b1;
                end
                ACCESS: begin
                    if (done) begin
                        ds.psel    <= 1'b0;
                        ds.penable <= 1'b0;
                        cnt        <= '0;
                        last_grant <= grant;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    ds.psel    <= 1'b0;
                    ds.penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: round-robin instance with a configurable slave,
// plus a fixed-priority instance fed the same upstream requests.
module tb_apb_master_arb;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        g;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          cyc;
    } xfer_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_master_arb_if m0 ();
    apb_master_arb_if m1 ();
    apb_master_arb_if ds ();
    apb_master_arb_if fm0 ();
    apb_master_arb_if fm1 ();
    apb_master_arb_if fds ();

    logic grant, timeout_evt, f_grant, f_timeout_evt;

    apb_master_arb #(.FIXED_PRIO(0), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .m0(m0), .m1(m1), .ds(ds),
        .grant(grant), .timeout_evt(timeout_evt)
    );

    apb_master_arb #(.FIXED_PRIO(1), .TIMEOUT(8)) dut_fp (
        .clk(clk), .rst(rst), .m0(fm0), .m1(fm1), .ds(fds),
        .grant(f_grant), .timeout_evt(f_timeout_evt)
    );

    assign fm0.psel    = m0.psel;
    assign fm0.penable = m0.penable;
    assign fm0.paddr   = m0.paddr;
    assign fm0.pwrite  = m0.pwrite;
    assign fm0.pwdata  = m0.pwdata;
    assign fm0.pwstrb  = m0.pwstrb;
    assign fm1.psel    = m1.psel;
    assign fm1.penable = m1.penable;
    assign fm1.paddr   = m1.paddr;
    assign fm1.pwrite  = m1.pwrite;
    assign fm1.pwdata  = m1.pwdata;
    assign fm1.pwstrb  = m1.pwstrb;
    assign fds.pready  = 1'b1;
    assign fds.prdata  = 32'h0;
    assign fds.pslverr = 1'b0;

    // Downstream slave: read data is the address nibble [7:4] replicated.
    logic ds_tie = 1'b0;
    logic ds_hang = 1'b0;
    logic ds_err = 1'b0;
    int   ds_wait = 0;
    int   wc = 0;
    assign ds.pready  = ds_tie || (ds.psel && ds.penable && !ds_hang && (wc >= ds_wait));
    assign ds.prdata  = {8{ds.paddr[7:4]}};
    assign ds.pslverr = ds_err;

    always @(posedge clk) begin
        if (rst || !(ds.psel && ds.penable) || ds.pready) wc <= 0;
        else wc <= wc + 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    xfer_t log_q[$];
    xfer_t snap;
    logic  f_log[$];
    int    stab_err = 0;
    int    spur = 0;
    int    to_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (ds.psel && !ds.penable) begin
                log_q.push_back('{grant, ds.paddr, ds.pwrite, ds.pwdata, ds.pwstrb, cyc});
                snap <= '{grant, ds.paddr, ds.pwrite, ds.pwdata, ds.pwstrb, cyc};
            end
            if (ds.psel && ds.penable && ((ds.paddr !== snap.addr) || (ds.pwrite !== snap.wr) ||
                (ds.pwdata !== snap.wdata) || (ds.pwstrb !== snap.strb) || (grant !== snap.g)))
                stab_err <= stab_err + 1;
            spur <= spur
                + int'(m0.pready && !(ds.psel && ds.penable && grant == 1'b0))
                + int'(m1.pready && !(ds.psel && ds.penable && grant == 1'b1))
                + int'(!m0.pready && (m0.pslverr || m0.prdata != 32'h0))
                + int'(!m1.pready && (m1.pslverr || m1.prdata != 32'h0));
            if (timeout_evt) to_cnt <= to_cnt + 1;
            if (fds.psel && !fds.penable) f_log.push_back(f_grant);
        end
    end

    exp_t sb0[$];
    exp_t sb1[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic clear_masters();
        m0.psel = 0; m0.penable = 0; m0.paddr = 0; m0.pwrite = 0; m0.pwdata = 0; m0.pwstrb = 0;
        m1.psel = 0; m1.penable = 0; m1.paddr = 0; m1.pwrite = 0; m1.pwdata = 0; m1.pwstrb = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_masters();
        ds_tie = 0; ds_hang = 0; ds_err = 0; ds_wait = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        log_q.delete();
        f_log.delete();
        sb0.delete();
        sb1.delete();
    endtask

    task automatic master_idle(input int idx);
        @(posedge clk); #1;
        if (idx == 0) begin m0.psel = 0; m0.penable = 0; end
        else begin m1.psel = 0; m1.penable = 0; end
    endtask

    // One upstream transfer; leaves psel high so callers can chain back-to-back.
    task automatic master_xfer(input int idx, input logic [31:0] addr, input logic wr,
                               input logic [31:0] wdata, input logic [3:0] strb, output int done_cyc);
        exp_t e;
        exp_t got;
        bit   seen;
        seen = 0;
        got = '0;
        done_cyc = -1;
        @(posedge clk); #1;
        e.rdata = ds_hang ? 32'h0 : {8{addr[7:4]}};
        e.err   = ds_hang ? 1'b1 : ds_err;
        if (idx == 0) begin
            m0.psel = 1; m0.penable = 0; m0.paddr = addr; m0.pwrite = wr; m0.pwdata = wdata; m0.pwstrb = strb;
            sb0.push_back(e);
        end else begin
            m1.psel = 1; m1.penable = 0; m1.paddr = addr; m1.pwrite = wr; m1.pwdata = wdata; m1.pwstrb = strb;
            sb1.push_back(e);
        end
        @(posedge clk); #1;
        if (idx == 0) m0.penable = 1; else m1.penable = 1;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (idx == 0 && m0.pready) begin
                seen = 1; got = '{m0.prdata, m0.pslverr}; e = sb0.pop_front(); done_cyc = cyc;
            end else if (idx == 1 && m1.pready) begin
                seen = 1; got = '{m1.prdata, m1.pslverr}; e = sb1.pop_front(); done_cyc = cyc;
            end
        end
        n_checks++;
        if (!seen) begin
            $display("FAIL xfer_m%0d_%h: no pready within 200 cycles, want a completion", idx, addr);
            if (idx == 0) sb0.delete(); else sb1.delete();
        end else if (got !== e) begin
            $display("FAIL xfer_m%0d_%h: got rdata=%h err=%b want rdata=%h err=%b",
                     idx, addr, got.rdata, got.err, e.rdata, e.err);
        end else n_pass++;
    endtask

    task automatic test_reset();
        ds_tie = 1'b1;
        #12;
        n_checks++; if ({ds.psel, ds.penable, ds.pwrite} !== 3'b000) $display("FAIL rst_ctrl: got %b want 000", {ds.psel, ds.penable, ds.pwrite}); else n_pass++;
        n_checks++; if (ds.paddr !== 32'h0) $display("FAIL rst_paddr: got %h want 0", ds.paddr); else n_pass++;
        n_checks++; if (ds.pwdata !== 32'h0) $display("FAIL rst_pwdata: got %h want 0", ds.pwdata); else n_pass++;
        n_checks++; if (ds.pwstrb !== 4'h0) $display("FAIL rst_pwstrb: got %h want 0", ds.pwstrb); else n_pass++;
        n_checks++; if (grant !== 1'b1) $display("FAIL rst_grant: got %b want 1", grant); else n_pass++;
        n_checks++; if (timeout_evt !== 1'b0) $display("FAIL rst_timeout_evt: got %b want 0", timeout_evt); else n_pass++;
        n_checks++; if ({m0.pready, m0.pslverr, m1.pready, m1.pslverr} !== 4'b0)
            $display("FAIL rst_up_resp: got %b want 0000", {m0.pready, m0.pslverr, m1.pready, m1.pslverr}); else n_pass++;
        n_checks++; if ({m0.prdata, m1.prdata} !== 64'h0) $display("FAIL rst_up_prdata: got %h want 0", {m0.prdata, m1.prdata}); else n_pass++;
        ds_tie = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_single_write();
        exp_t e;
        int   s0;
        apply_reset();
        s0 = spur;
        ds_tie = 1'b1;
        @(posedge clk); #1;
        m0.psel = 1; m0.penable = 0; m0.paddr = 32'h1000_0004; m0.pwrite = 1; m0.pwdata = 32'hDEAD_BEEF; m0.pwstrb = 4'hF;
        e.rdata = {8{m0.paddr[7:4]}}; e.err = 1'b0;
        sb0.push_back(e);
        @(negedge clk);
        n_checks++; if ({ds.psel, m0.pready} !== 2'b00) $display("FAIL sw_t0: got psel,pready=%b want 00", {ds.psel, m0.pready}); else n_pass++;
        @(posedge clk); #1 m0.penable = 1;
        @(negedge clk);
        n_checks++; if ({ds.psel, ds.penable, ds.pwrite, m0.pready} !== 4'b1010)
            $display("FAIL sw_t1_ctrl: got psel,penable,pwrite,pready=%b want 1010", {ds.psel, ds.penable, ds.pwrite, m0.pready}); else n_pass++;
        n_checks++; if (ds.paddr !== 32'h1000_0004) $display("FAIL sw_t1_paddr: got %h want 10000004", ds.paddr); else n_pass++;
        n_checks++; if (ds.pwdata !== 32'hDEAD_BEEF) $display("FAIL sw_t1_pwdata: got %h want deadbeef", ds.pwdata); else n_pass++;
        n_checks++; if (ds.pwstrb !== 4'hF) $display("FAIL sw_t1_pwstrb: got %h want f", ds.pwstrb); else n_pass++;
        @(negedge clk);
        n_checks++; if ({ds.psel, ds.penable} !== 2'b11) $display("FAIL sw_t2_ctrl: got %b want 11", {ds.psel, ds.penable}); else n_pass++;
        n_checks++; if ({m0.pready, m1.pready, grant} !== 3'b100) $display("FAIL sw_t2_pready: got m0,m1,grant=%b want 100", {m0.pready, m1.pready, grant}); else n_pass++;
        e = sb0.pop_front();
        n_checks++; if ({m0.prdata, m0.pslverr} !== {e.rdata, e.err})
            $display("FAIL sw_resp: got %h/%b want %h/%b", m0.prdata, m0.pslverr, e.rdata, e.err); else n_pass++;
        master_idle(0);
        @(negedge clk);
        n_checks++; if (ds.psel !== 1'b0) $display("FAIL sw_t3_psel: got %b want 0", ds.psel); else n_pass++;
        n_checks++; if (spur - s0 != 0) $display("FAIL sw_spurious: got %0d want 0", spur - s0); else n_pass++;
        ds_tie = 1'b0;
    endtask

    task automatic test_simultaneous();
        int d0, d1, s0;
        apply_reset();
        s0 = spur;
        fork
            begin master_xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, d0); master_idle(0); end
            begin master_xfer(1, 32'h20, 1'b0, 32'h0, 4'h0, d1); master_idle(1); end
        join
        n_checks++; if (log_q.size() != 2) $display("FAIL sim_count: got %0d want 2", log_q.size()); else n_pass++;
        if (log_q.size() >= 2) begin
            n_checks++; if ({log_q[0].g, log_q[0].addr} !== {1'b0, 32'h10}) $display("FAIL sim_first: got g=%b a=%h want g=0 a=10", log_q[0].g, log_q[0].addr); else n_pass++;
            n_checks++; if ({log_q[1].g, log_q[1].addr} !== {1'b1, 32'h20}) $display("FAIL sim_second: got g=%b a=%h want g=1 a=20", log_q[1].g, log_q[1].addr); else n_pass++;
            n_checks++; if (log_q[1].cyc - log_q[0].cyc != 3) $display("FAIL sim_idle_gap: got %0d want 3", log_q[1].cyc - log_q[0].cyc); else n_pass++;
            n_checks++; if (d0 - log_q[0].cyc != 1) $display("FAIL sim_latency: got %0d want 1", d0 - log_q[0].cyc); else n_pass++;
        end
        n_checks++; if (spur - s0 != 0) $display("FAIL sim_spurious: got %0d want 0", spur - s0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int   d0, d1, bad_g, bad_gap, f_ones;
        logic f_snap[$];
        apply_reset();
        fork
            begin
                for (int i = 0; i < 3; i++) master_xfer(0, 32'h100 + 32'(i) * 32'h10, 1'b0, 32'h0, 4'h0, d0);
                f_snap = f_log;
                master_idle(0);
            end
            begin
                for (int j = 0; j < 3; j++) master_xfer(1, 32'h200 + 32'(j) * 32'h10, 1'b1, 32'hA5A5_0000 + 32'(j), 4'h5, d1);
                master_idle(1);
            end
        join
        n_checks++; if (log_q.size() != 6) $display("FAIL rr_count: got %0d want 6", log_q.size()); else n_pass++;
        bad_g = 0;
        bad_gap = 0;
        for (int k = 0; k < 6 && k < log_q.size(); k++) begin
            if ({log_q[k].g, log_q[k].addr} !== {1'(k % 2), ((k % 2) != 0 ? 32'h200 : 32'h100) + 32'(k / 2) * 32'h10}) bad_g++;
            if (k > 0 && log_q[k].cyc - log_q[k-1].cyc != 3) bad_gap++;
        end
        n_checks++; if (bad_g != 0) $display("FAIL rr_sequence: got %0d out-of-order grants want 0", bad_g); else n_pass++;
        n_checks++; if (bad_gap != 0) $display("FAIL rr_gap: got %0d bad gaps want 0", bad_gap); else n_pass++;
        f_ones = 0;
        foreach (f_snap[k]) if (f_snap[k] !== 1'b0) f_ones++;
        n_checks++; if (f_snap.size() < 3) $display("FAIL fp_count: got %0d want >=3", f_snap.size()); else n_pass++;
        n_checks++; if (f_ones != 0) $display("FAIL fp_m0_wins: got %0d grants to m1 want 0", f_ones); else n_pass++;
    endtask

    task automatic test_wait_states();
        int d0, s0, t0;
        log_q.delete();
        s0 = stab_err;
        t0 = to_cnt;
        ds_wait = 5;
        ds_err = 1'b1;
        fork
            begin master_xfer(0, 32'h40, 1'b1, 32'hCAFE_F00D, 4'h3, d0); master_idle(0); end
            begin repeat (4) @(posedge clk); #2; m0.paddr = 32'hBAD0; m0.pwdata = 0; m0.pwstrb = 0; m0.pwrite = 0; end
        join
        n_checks++; if (log_q.size() != 1) $display("FAIL ws_count: got %0d want 1", log_q.size()); else n_pass++;
        if (log_q.size() >= 1) begin
            n_checks++; if ({log_q[0].addr, log_q[0].wr, log_q[0].wdata, log_q[0].strb} !== {32'h40, 1'b1, 32'hCAFE_F00D, 4'h3})
                $display("FAIL ws_setup: got a=%h w=%b d=%h s=%h want 40/1/cafef00d/3", log_q[0].addr, log_q[0].wr, log_q[0].wdata, log_q[0].strb); else n_pass++;
            n_checks++; if (d0 - log_q[0].cyc != 6) $display("FAIL ws_latency: got %0d want 6", d0 - log_q[0].cyc); else n_pass++;
        end
        n_checks++; if (stab_err - s0 != 0) $display("FAIL ws_stable: got %0d changes want 0", stab_err - s0); else n_pass++;
        n_checks++; if (to_cnt - t0 != 0) $display("FAIL ws_no_timeout: got %0d want 0", to_cnt - t0); else n_pass++;
        ds_wait = 0;
        ds_err = 1'b0;
    endtask

    task automatic test_timeout();
        int d0, t0;
        log_q.delete();
        t0 = to_cnt;
        ds_hang = 1'b1;
        master_xfer(0, 32'h30, 1'b0, 32'h0, 4'h0, d0);
        n_checks++; if (timeout_evt !== 1'b1) $display("FAIL to_evt_high: got %b want 1", timeout_evt); else n_pass++;
        master_idle(0);
        @(negedge clk);
        n_checks++; if ({ds.psel, timeout_evt} !== 2'b00) $display("FAIL to_after: got psel,evt=%b want 00", {ds.psel, timeout_evt}); else n_pass++;
        n_checks++; if (to_cnt - t0 != 1) $display("FAIL to_pulses: got %0d want 1", to_cnt - t0); else n_pass++;
        if (log_q.size() >= 1) begin
            n_checks++; if (d0 - log_q[0].cyc != 8) $display("FAIL to_latency: got %0d want 8", d0 - log_q[0].cyc); else n_pass++;
        end
        ds_hang = 1'b0;
    endtask

    task automatic test_reset_mid();
        int  d0, d1, s0, t0;
        bit  in_access;
        s0 = spur;
        t0 = to_cnt;
        in_access = 0;
        ds_hang = 1'b1;
        @(posedge clk); #1;
        m0.psel = 1; m0.penable = 0; m0.paddr = 32'h50; m0.pwrite = 0;
        @(posedge clk); #1 m0.penable = 1;
        for (int k = 0; k < 20 && !in_access; k++) begin
            @(negedge clk);
            if (ds.psel && ds.penable) in_access = 1;
        end
        n_checks++; if (!in_access) $display("FAIL rm_reach_access: got no ACCESS within 20 cycles want ACCESS"); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({ds.psel, ds.penable, m0.pready, grant} !== 4'b0001)
            $display("FAIL rm_async: got psel,penable,pready,grant=%b want 0001", {ds.psel, ds.penable, m0.pready, grant}); else n_pass++;
        clear_masters();
        ds_hang = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        log_q.delete();
        fork
            begin master_xfer(1, 32'h70, 1'b0, 32'h0, 4'h0, d1); master_idle(1); end
            begin master_xfer(0, 32'h60, 1'b0, 32'h0, 4'h0, d0); master_idle(0); end
        join
        n_checks++; if (log_q.size() < 1 || log_q[0].g !== 1'b0) $display("FAIL rm_first_grant: got %b want 0", (log_q.size() > 0) ? log_q[0].g : 1'bx); else n_pass++;
        n_checks++; if (spur - s0 != 0) $display("FAIL rm_spurious: got %0d want 0", spur - s0); else n_pass++;
        n_checks++; if (to_cnt - t0 != 0) $display("FAIL rm_no_timeout: got %0d want 0", to_cnt - t0); else n_pass++;
    endtask

    initial begin
        clear_masters();
        test_reset();
        test_single_write();
        test_simultaneous();
        test_back_to_back();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        n_checks++; if (spur != 0) $display("FAIL spurious_total: got %0d want 0", spur); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
